pe_feeder: RTL and testbench

- Upstream loader for one processing element (PE).
- On start, reads 3 filter weights then 32 ifmap words from a synchronous global-buffer SRAM port.
- Streams them word-serially into the PE's weight/ifmap FIFOs using the PE's value/weight_wea/ifmap_wea interface.
- Waits for the PE's Ready, asserts done when the whole row has been pushed.

---
 rtl/pe_feeder.sv | 196 +++++++++++++++++++
 tb/tb_pe_feeder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Upstream loader for one PE: fetches WEIGHT_LEN weights then IFMAP_LEN ifmap words
// from a global-buffer SRAM port and pushes them word-serially into the PE FIFOs.
module pe_feeder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned WEIGHT_LEN = 3,
    parameter int unsigned IFMAP_LEN  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] ifmap_base,
    input  logic              pe_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] value,
    output logic              weight_wea,
    output logic              ifmap_wea,
    output logic              busy,
    output logic              done
);

    localparam int unsigned N     = WEIGHT_LEN + IFMAP_LEN;
    localparam int unsigned IDX_W = $clog2(N + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_wbase;
    logic [ADDR_W-1:0] r_ibase;
    logic              r_rd_en;
    logic              r_rd_w;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_value;
    logic              r_wwea;
    logic              r_iwea;
    logic              r_busy;
    logic              r_done;

    logic [2:0]        w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [ADDR_W-1:0] w_wbase_nxt;
    logic [ADDR_W-1:0] w_ibase_nxt;
    logic              w_rd_en_nxt;
    logic              w_rd_w_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_value_nxt;
    logic              w_wwea_nxt;
    logic              w_iwea_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;

    logic              w_issue;
    logic [IDX_W-1:0]  w_issue_idx;
    logic [ADDR_W-1:0] w_wb;
    logic [ADDR_W-1:0] w_ib;

    // Next-state and output logic; the read issued on an edge is pushed on the following edge.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wbase_nxt = r_wbase;
        w_ibase_nxt = r_ibase;
        w_rd_en_nxt = 1'b0;
        w_rd_w_nxt  = r_rd_w;
        w_addr_nxt  = r_addr;
        w_value_nxt = r_value;
        w_wwea_nxt  = 1'b0;
        w_iwea_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_issue     = 1'b0;
        w_issue_idx = r_idx;
        w_wb        = r_wbase;
        w_ib        = r_ibase;

        if (r_rd_en) begin
            w_value_nxt = mem_rdata;
            w_wwea_nxt  = r_rd_w;
            w_iwea_nxt  = ~r_rd_w;
        end

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_wbase_nxt = weight_base;
                    w_ibase_nxt = ifmap_base;
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    if (pe_ready) begin
                        w_issue     = 1'b1;
                        w_issue_idx = '0;
                        w_wb        = weight_base;
                        w_ib        = ifmap_base;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (pe_ready) begin
                    w_issue     = 1'b1;
                    w_issue_idx = '0;
                end
            end
            S_FETCH: begin
                w_issue = 1'b1;
            end
            S_DRAIN: begin
                // Last push cycle: no read outstanding but a strobe is still high.
                if (!r_rd_en && (r_wwea || r_iwea)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (w_issue) begin
            w_rd_en_nxt = 1'b1;
            if (w_issue_idx < IDX_W'(WEIGHT_LEN)) begin
                w_rd_w_nxt = 1'b1;
                w_addr_nxt = w_wb + ADDR_W'(w_issue_idx);
            end else begin
                w_rd_w_nxt = 1'b0;
                w_addr_nxt = w_ib + ADDR_W'(w_issue_idx - IDX_W'(WEIGHT_LEN));
            end
            w_idx_nxt   = w_issue_idx + IDX_W'(1);
            w_state_nxt = (w_issue_idx == IDX_W'(N - 1)) ? S_DRAIN : S_FETCH;
        end

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_rd_en_nxt = 1'b0;
            w_wwea_nxt  = 1'b0;
            w_iwea_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_value_nxt = r_value;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_wbase <= '0;
            r_ibase <= '0;
            r_rd_en <= 1'b0;
            r_rd_w  <= 1'b0;
            r_addr  <= '0;
            r_value <= '0;
            r_wwea  <= 1'b0;
            r_iwea  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wbase <= w_wbase_nxt;
            r_ibase <= w_ibase_nxt;
            r_rd_en <= w_rd_en_nxt;
            r_rd_w  <= w_rd_w_nxt;
            r_addr  <= w_addr_nxt;
            r_value <= w_value_nxt;
            r_wwea  <= w_wwea_nxt;
            r_iwea  <= w_iwea_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign value      = r_value;
    assign weight_wea = r_wwea;
    assign ifmap_wea  = r_iwea;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: cycle timeline derived from the transfer rules,
// SRAM data = address + salt, plus a small PE FIFO occupancy model.
module tb_pe_feeder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int WL     = 3;
    localparam int IL     = 32;
    localparam int N      = WL + IL;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] weight_base;
    logic [ADDR_W-1:0] ifmap_base;
    logic              pe_ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] value;
    logic              weight_wea;
    logic              ifmap_wea;
    logic              busy;
    logic              done;

    logic              tb_ready;
    logic              pe_model;
    logic              pe_clr;
    logic [31:0]       salt;
    int                pe_wcnt;
    int                pe_icnt;
    int                vectors = 0;
    int                miscompares = 0;

    always #5 clk = ~clk;

    pe_feeder dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .weight_base(weight_base), .ifmap_base(ifmap_base), .pe_ready(pe_ready),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .value(value), .weight_wea(weight_wea), .ifmap_wea(ifmap_wea),
        .busy(busy), .done(done)
    );

    // SRAM: word for the read presented this cycle; poison when no read is active.
    assign mem_rdata = mem_rd_en ? (DATA_W'(mem_addr) + salt) : 32'hDEAD_BEEF;

    // PE: counts pushes it samples; Ready drops once both FIFOs are full.
    always @(posedge clk) begin
        if (pe_clr) begin
            pe_wcnt <= 0;
            pe_icnt <= 0;
        end else begin
            if (weight_wea) pe_wcnt <= pe_wcnt + 1;
            if (ifmap_wea)  pe_icnt <= pe_icnt + 1;
        end
    end
    assign pe_ready = pe_model ? !(pe_wcnt >= WL && pe_icnt >= IL) : tb_ready;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] wb,
                                                  input logic [ADDR_W-1:0] ib, input int n);
        if (n < WL) return wb + ADDR_W'(n);
        return ib + ADDR_W'(n - WL);
    endfunction

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) + salt;
    endfunction

    // One transfer; k counts edges from the FETCH-entry edge E.
    task automatic run_transfer(input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ib,
                                input int wait_n, input int abort_k, input int restart_k,
                                input int reset_k);
        logic [4:0]        ex_ctl;
        logic [ADDR_W-1:0] ex_addr;
        logic [DATA_W-1:0] ex_val;
        int                p;
        bit                stop;
        @(negedge clk);
        start = 1'b1; weight_base = wb; ifmap_base = ib; tb_ready = (wait_n == 0);
        for (int w = 0; w < wait_n; w++) begin
            @(posedge clk); @(negedge clk);
            start = 1'b0;
            vectors++;
            if ({mem_rd_en, weight_wea, ifmap_wea, busy, done} !== 5'b00010) begin
                miscompares++;
                $display("FAIL wait_ready cyc=%0d: rd/wwea/iwea/busy/done=%b want 00010",
                         w, {mem_rd_en, weight_wea, ifmap_wea, busy, done});
            end
            if (w == wait_n - 1) tb_ready = 1'b1;
        end
        stop = 0;
        for (int k = 0; k <= N + 3 && !stop; k++) begin
            @(posedge clk); @(negedge clk);
            start = 1'b0; weight_base = wb; ifmap_base = ib;
            p = k - 1;
            ex_ctl = {k < N, p >= 0 && p < WL, p >= WL && p < N, k <= N + 1, k == N + 1};
            vectors++;
            if ({mem_rd_en, weight_wea, ifmap_wea, busy, done} !== ex_ctl) begin
                miscompares++;
                $display("FAIL stream_ctl k=%0d: rd/wwea/iwea/busy/done=%b want %b",
                         k, {mem_rd_en, weight_wea, ifmap_wea, busy, done}, ex_ctl);
            end
            if (k < N) begin
                ex_addr = addr_of(wb, ib, k);
                vectors++;
                if (mem_addr !== ex_addr) begin
                    miscompares++;
                    $display("FAIL stream_addr k=%0d: got %h want %h", k, mem_addr, ex_addr);
                end
            end
            if (k >= 1) begin
                ex_val = data_of(addr_of(wb, ib, (p < N) ? p : N - 1));
                vectors++;
                if (value !== ex_val) begin
                    miscompares++;
                    $display("FAIL stream_value k=%0d: got %h want %h", k, value, ex_val);
                end
            end
            if (k == restart_k) begin
                start = 1'b1; weight_base = ~wb; ifmap_base = ~ib;
            end
            if (k == abort_k) begin
                abort = 1'b1;
                @(posedge clk); @(negedge clk);
                abort = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    vectors++;
                    if ({mem_rd_en, weight_wea, ifmap_wea, busy, done} !== 5'b0) begin
                        miscompares++;
                        $display("FAIL abort_idle j=%0d: rd/wwea/iwea/busy/done=%b want 00000",
                                 j, {mem_rd_en, weight_wea, ifmap_wea, busy, done});
                    end
                    @(posedge clk); @(negedge clk);
                end
                stop = 1;
            end
            if (k == reset_k) begin
                rstn = 1'b0;
                #1;
                vectors++;
                if ({mem_rd_en, mem_addr, value, weight_wea, ifmap_wea, busy, done} !== '0) begin
                    miscompares++;
                    $display("FAIL async_reset: rd=%b addr=%h val=%h wwea=%b iwea=%b busy=%b done=%b want all 0",
                             mem_rd_en, mem_addr, value, weight_wea, ifmap_wea, busy, done);
                end
                @(negedge clk);
                rstn = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(posedge clk); @(negedge clk);
                    vectors++;
                    if ({mem_rd_en, weight_wea, ifmap_wea, busy, done} !== 5'b0) begin
                        miscompares++;
                        $display("FAIL post_reset j=%0d: rd/wwea/iwea/busy/done=%b want 00000",
                                 j, {mem_rd_en, weight_wea, ifmap_wea, busy, done});
                    end
                end
                stop = 1;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; abort = 1'b0; tb_ready = 1'b0; pe_model = 1'b0;
        pe_clr = 1'b1; salt = 32'h0; weight_base = '0; ifmap_base = '0;
        #12;
        vectors++;
        if ({mem_rd_en, mem_addr, value, weight_wea, ifmap_wea, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rd=%b addr=%h val=%h wwea=%b iwea=%b busy=%b done=%b want all 0",
                     mem_rd_en, mem_addr, value, weight_wea, ifmap_wea, busy, done);
        end
        @(negedge clk);
        rstn = 1'b1; pe_clr = 1'b0;
        abort = 1'b1; tb_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({mem_rd_en, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_in_idle: rd/busy/done=%b want 000", {mem_rd_en, busy, done});
        end
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; abort = 1'b0;
        vectors++;
        if ({mem_rd_en, weight_wea, ifmap_wea, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL start_with_abort: rd/wwea/iwea/busy/done=%b want 00000",
                     {mem_rd_en, weight_wea, ifmap_wea, busy, done});
        end
    endtask

    task automatic test_basic();
        salt = 32'h0000_A000;
        run_transfer(10'h010, 10'h100, 0, -1, -1, -1);
    endtask

    task automatic test_wait_ready();
        run_transfer(10'h010, 10'h100, 10, -1, -1, -1);
    endtask

    task automatic test_wrap();
        salt = 32'h5500_0000;
        run_transfer(10'h3FE, 10'h3F0, 0, -1, -1, -1);
    endtask

    task automatic test_abort();
        salt = $urandom;
        run_transfer(10'($urandom), 10'($urandom), 0, 11, -1, -1);
        run_transfer(10'($urandom), 10'($urandom), 0, -1, -1, -1);
    endtask

    task automatic test_restart_and_reset();
        salt = $urandom;
        run_transfer(10'($urandom), 10'($urandom), 0, -1, 5, -1);
        run_transfer(10'($urandom), 10'($urandom), 2, -1, N + 1, -1);
        run_transfer(10'($urandom), 10'($urandom), 0, -1, -1, 20);
        run_transfer(10'($urandom), 10'($urandom), 0, -1, -1, -1);
    endtask

    task automatic test_pe_connected();
        @(negedge clk);
        pe_clr = 1'b1;
        @(negedge clk);
        pe_clr = 1'b0; pe_model = 1'b1; salt = $urandom;
        run_transfer(10'($urandom), 10'($urandom), 0, -1, -1, -1);
        vectors++;
        if (pe_wcnt !== WL || pe_icnt !== IL || pe_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pe_fifo_full: wcnt=%0d icnt=%0d ready=%b want %0d %0d 0",
                     pe_wcnt, pe_icnt, pe_ready, WL, IL);
        end
        pe_model = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 6; t++) begin
            salt = $urandom;
            run_transfer(10'($urandom), 10'($urandom), int'($urandom_range(0, 3)), -1, -1, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_wait_ready();
        test_wrap();
        test_abort();
        test_restart_and_reset();
        test_pe_connected();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
